regfile_mp: RTL and testbench

Parametrised multi-port register file for the c2 core, and the successor to the current 2-read/1-write file. It adds:
- N_RD read ports with registered outputs and same-cycle write forwarding.
- Two write ports with defined priority.
- A per-register busy scoreboard.
- A post-reset clear sweep.
It sits between decode (read and scoreboard issue) and writeback (two retire lanes).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_sb.sv | 56 +++++
 rtl/regfile_mp.sv | 149 ++++++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ==== regfile_pkg : shared constants, state type and PC offset helper -- rev 1.0 ====
`default_nettype none

package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_ONE  = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  function automatic int unsigned pc_delta(input int unsigned microops_enabled);
    return (microops_enabled != 0) ? 32'd1 : 32'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb.sv
// ==== regfile_sb : per-register busy scoreboard with N_RD clear-bypassed lookups -- rev 1.0 ====
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int NREGS  = 32,
  parameter  int N_RD   = 2,
  parameter  int PC_REG = NREGS - 1,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_a_en,
  input  logic [ADDR_W-1:0]      clr_a_addr,
  input  logic                   clr_b_en,
  input  logic [ADDR_W-1:0]      clr_b_addr,
  input  logic [N_RD*ADDR_W-1:0] lk_addr,
  output logic [N_RD-1:0]        lk_busy
);

  localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(REG_ONE);
  localparam logic [ADDR_W-1:0] A_PC   = ADDR_W'(PC_REG);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr;
  logic             set_ok;

  assign set_ok = set_en && (set_addr != A_ZERO) && (set_addr != A_ONE) && (set_addr != A_PC);

  // Set is applied after clear so a newly issued producer overrides a retiring one.
  always_comb begin
    clr = '0;
    if (clr_a_en) clr[clr_a_addr] = 1'b1;
    if (clr_b_en) clr[clr_b_addr] = 1'b1;
    busy_d = busy_q & ~clr;
    if (set_ok) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_lk
    logic [ADDR_W-1:0] a;
    assign a          = lk_addr[k*ADDR_W +: ADDR_W];
    assign lk_busy[k] = busy_q[a] & ~clr[a];
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ==== regfile_mp : multi-port register file with forwarding, dual write, scoreboard, clear sweep -- rev 1.0 ====
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W           = 32,
  parameter  int NREGS            = 32,
  parameter  int N_RD             = 2,
  parameter  int MICROOPS_ENABLED = 1,
  parameter  int PC_REG           = NREGS - 1,
  localparam int ADDR_W           = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      pc,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wa_we,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic [DATA_W-1:0]      wa_data,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  output logic                   init_done,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data
);

  localparam logic [ADDR_W-1:0] A_ZERO   = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(REG_ONE);
  localparam logic [ADDR_W-1:0] A_PC     = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(NREGS - 1);
  localparam logic [DATA_W-1:0] PC_DELTA = DATA_W'(pc_delta(MICROOPS_ENABLED));

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [DATA_W-1:0] dbg_q, dbg_d;
  logic              run;
  logic              wa_en, wb_en, sb_en;
  logic [N_RD-1:0]   lk_busy;

  assign run   = (state_q == RUN);
  assign wa_en = run && wa_we;
  assign wb_en = run && wb_we;
  assign sb_en = run && sb_set;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == A_LAST) state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // wb is applied last so it wins a same-address collision with wa.
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (wa_en) mem_d[wa_addr] = wa_data;
      if (wb_en) mem_d[wb_addr] = wb_data;
    end
  end

  // Storage has no reset; the sweep zeroes it before it becomes visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dbg_d = mem_q[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= dbg_d;
  end

  assign dbg_data  = dbg_q;
  assign init_done = run;

  regfile_sb #(
    .NREGS  (NREGS),
    .N_RD   (N_RD),
    .PC_REG (PC_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (sb_en),
    .set_addr   (sb_addr),
    .clr_a_en   (wa_en),
    .clr_a_addr (wa_addr),
    .clr_b_en   (wb_en),
    .clr_b_addr (wb_addr),
    .lk_addr    (rd_addr),
    .lk_busy    (lk_busy)
  );

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              busy_q, busy_d;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign busy_d = lk_busy[k];

    always_comb begin
      rd_d = '0;
      if (addr == A_ZERO)                 rd_d = '0;
      else if (addr == A_ONE)             rd_d = DATA_W'(1);
      else if (addr == A_PC)              rd_d = pc + PC_DELTA;
      else if (wb_en && wb_addr == addr)  rd_d = wb_data;
      else if (wa_en && wa_addr == addr)  rd_d = wa_data;
      else if (run)                       rd_d = mem_q[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        rd_q   <= rd_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
    assign rd_busy[k]                  = busy_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ==== tb_regfile_mp : directed self-checking bench for regfile_mp (N_RD=4 +1 build, N_RD=2 +2 build) -- rev 1.0 ====
`default_nettype none

module tb_regfile_mp;

  logic         clk;
  logic         rst;
  logic [31:0]  pc;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         wa_we, wb_we, sb_set;
  logic [4:0]   wa_addr, wb_addr, sb_addr, dbg_addr;
  logic [31:0]  wa_data, wb_data;
  logic         init_done;
  logic [31:0]  dbg_data;

  logic [9:0]   rd_addr2;
  logic [63:0]  rd_data2;
  logic [1:0]   rd_busy2;
  logic         init_done2;
  logic [31:0]  dbg_data2;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign rd_addr2 = rd_addr[9:0];

  regfile_mp #(.DATA_W(32), .NREGS(32), .N_RD(4), .MICROOPS_ENABLED(1)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.DATA_W(32), .NREGS(32), .N_RD(2), .MICROOPS_ENABLED(0)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_done2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic writes_off;
    wa_we = 0; wb_we = 0; sb_set = 0;
  endtask

  task automatic test_reset;
    #3;
    total_cnt++; if (rd_data !== 128'd0) $display("FAIL reset_rd_data got=%h exp=0", rd_data); else pass_cnt++;
    total_cnt++; if (rd_busy !== 4'd0) $display("FAIL reset_rd_busy got=%b exp=0000", rd_busy); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'd0) $display("FAIL reset_dbg_data got=%h exp=0", dbg_data); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done got=%b exp=0", init_done); else pass_cnt++;
    tick; tick;
  endtask

  task automatic test_sweep;
    int lows = 0;
    int bad = 0;
    set_rd(5, 0, 0, 0);
    rst = 0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin wa_we = 1; wa_addr = 5; wa_data = 32'h55; end
      if (i == 12) begin sb_set = 1; sb_addr = 9; end
      tick;
      writes_off;
      if (init_done === 1'b0) lows++;
      if (i == 11) begin
        total_cnt++; if (rd_data[31:0] !== 32'd0) $display("FAIL sweep_read_zero got=%h exp=0", rd_data[31:0]); else pass_cnt++;
      end
    end
    total_cnt++; if (lows != 31) $display("FAIL sweep_init_low_cycles got=%0d exp=31", lows); else pass_cnt++;
    tick;
    total_cnt++; if (init_done !== 1'b1) $display("FAIL sweep_init_done got=%b exp=1", init_done); else pass_cnt++;
    set_rd(9, 0, 0, 0);
    tick;
    total_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL sweep_sb_ignored got=%b exp=0", rd_busy[0]); else pass_cnt++;
    for (int a = 2; a <= 30; a++) begin
      set_rd(5'(a), 0, 0, 0);
      tick;
      if (rd_data[31:0] !== 32'd0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL sweep_all_zero nonzero_regs=%0d exp=0", bad); else pass_cnt++;
    dbg_addr = 5;
    tick;
    total_cnt++; if (dbg_data !== 32'd0) $display("FAIL sweep_wa_ignored got=%h exp=0", dbg_data); else pass_cnt++;
  endtask

  task automatic test_constants;
    pc = 32'h100;
    set_rd(0, 31, 1, 31);
    tick;
    total_cnt++; if (rd_data[31:0] !== 32'd0) $display("FAIL const_r0 got=%h exp=0", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (rd_data[95:64] !== 32'd1) $display("FAIL const_r1 got=%h exp=1", rd_data[95:64]); else pass_cnt++;
    total_cnt++; if (rd_data[63:32] !== 32'h101) $display("FAIL const_pc_d1 got=%h exp=101", rd_data[63:32]); else pass_cnt++;
    total_cnt++; if (rd_data2[63:32] !== 32'h102) $display("FAIL const_pc_d2 got=%h exp=102", rd_data2[63:32]); else pass_cnt++;
    pc = 32'hFFFF_FFFF;
    tick;
    total_cnt++; if (rd_data[63:32] !== 32'd0) $display("FAIL const_pc_wrap1 got=%h exp=0", rd_data[63:32]); else pass_cnt++;
    total_cnt++; if (rd_data2[63:32] !== 32'd1) $display("FAIL const_pc_wrap2 got=%h exp=1", rd_data2[63:32]); else pass_cnt++;
    pc = 32'h100;
  endtask

  task automatic test_forwarding;
    wa_we = 1; wa_addr = 7; wa_data = 32'hAAAA;
    wb_we = 1; wb_addr = 7; wb_data = 32'h5555;
    set_rd(7, 0, 0, 0);
    tick;
    writes_off;
    total_cnt++; if (rd_data[31:0] !== 32'h5555) $display("FAIL fwd_wb_wins got=%h exp=5555", rd_data[31:0]); else pass_cnt++;
    dbg_addr = 7;
    tick;
    total_cnt++; if (rd_data[31:0] !== 32'h5555) $display("FAIL fwd_mem_r7 got=%h exp=5555", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h5555) $display("FAIL fwd_dbg_r7 got=%h exp=5555", dbg_data); else pass_cnt++;
    wa_we = 1; wa_addr = 8; wa_data = 32'h1234;
    set_rd(8, 0, 0, 0);
    tick;
    writes_off;
    total_cnt++; if (rd_data[31:0] !== 32'h1234) $display("FAIL fwd_wa got=%h exp=1234", rd_data[31:0]); else pass_cnt++;
    wa_we = 1; wa_addr = 10; wa_data = 32'h10;
    wb_we = 1; wb_addr = 11; wb_data = 32'h11;
    tick;
    writes_off;
    set_rd(10, 11, 0, 0);
    tick;
    total_cnt++; if (rd_data[63:0] !== {32'h11, 32'h10}) $display("FAIL dual_write got=%h exp=0000001100000010", rd_data[63:0]); else pass_cnt++;
    wb_we = 1; wb_addr = 0; wb_data = 32'hDEAD;
    set_rd(0, 0, 0, 0);
    dbg_addr = 0;
    tick;
    writes_off;
    tick;
    total_cnt++; if (rd_data[31:0] !== 32'd0) $display("FAIL write_r0_hidden got=%h exp=0", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'hDEAD) $display("FAIL write_r0_raw got=%h exp=dead", dbg_data); else pass_cnt++;
  endtask

  task automatic test_scoreboard;
    sb_set = 1; sb_addr = 9;
    set_rd(9, 0, 0, 0);
    tick;
    total_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL sb_set_no_bypass got=%b exp=0", rd_busy[0]); else pass_cnt++;
    sb_set = 0;
    tick;
    total_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL sb_busy got=%b exp=1", rd_busy[0]); else pass_cnt++;
    wa_we = 1; wa_addr = 9; wa_data = 32'd3;
    tick;
    writes_off;
    total_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL sb_clr_bypass got=%b exp=0", rd_busy[0]); else pass_cnt++;
    total_cnt++; if (rd_data[31:0] !== 32'd3) $display("FAIL sb_clr_data got=%h exp=3", rd_data[31:0]); else pass_cnt++;
    tick;
    total_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL sb_cleared got=%b exp=0", rd_busy[0]); else pass_cnt++;
    sb_set = 1; sb_addr = 9;
    wb_we = 1; wb_addr = 9; wb_data = 32'd7;
    tick;
    writes_off;
    tick;
    total_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL sb_set_wins got=%b exp=1", rd_busy[0]); else pass_cnt++;
    total_cnt++; if (rd_data[31:0] !== 32'd7) $display("FAIL sb_set_wins_data got=%h exp=7", rd_data[31:0]); else pass_cnt++;
    wa_we = 1; wa_addr = 9; wa_data = 32'd9;
    tick;
    writes_off;
    sb_set = 1; sb_addr = 31; tick;
    sb_addr = 1; tick;
    sb_addr = 0; tick;
    sb_set = 0;
    set_rd(31, 1, 0, 9);
    tick;
    total_cnt++; if (rd_busy !== 4'b0000) $display("FAIL sb_const_ignored got=%b exp=0000", rd_busy); else pass_cnt++;
  endtask

  task automatic test_nrd4;
    wa_we = 1; wa_addr = 2; wa_data = 32'd10;
    wb_we = 1; wb_addr = 3; wb_data = 32'd20;
    tick;
    writes_off;
    pc = 32'h100;
    set_rd(2, 3, 31, 0);
    tick;
    total_cnt++; if (rd_data !== {32'd0, 32'h101, 32'd20, 32'd10}) $display("FAIL nrd4_ports got=%h exp=%h", rd_data, {32'd0, 32'h101, 32'd20, 32'd10}); else pass_cnt++;
    total_cnt++; if (rd_data2 !== {32'd20, 32'd10}) $display("FAIL nrd2_ports got=%h exp=%h", rd_data2, {32'd20, 32'd10}); else pass_cnt++;
  endtask

  task automatic test_midrun_reset;
    int lows = 0;
    wa_we = 1; wa_addr = 4; wa_data = 32'h77;
    sb_set = 1; sb_addr = 12;
    tick;
    writes_off;
    set_rd(4, 12, 0, 0);
    dbg_addr = 4;
    tick;
    total_cnt++; if (rd_data[31:0] !== 32'h77) $display("FAIL mid_pre_r4 got=%h exp=77", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (rd_busy[1] !== 1'b1) $display("FAIL mid_pre_busy got=%b exp=1", rd_busy[1]); else pass_cnt++;
    #2 rst = 1;
    #1;
    total_cnt++; if (rd_data !== 128'd0) $display("FAIL mid_rst_rd_data got=%h exp=0", rd_data); else pass_cnt++;
    total_cnt++; if (rd_busy !== 4'd0) $display("FAIL mid_rst_rd_busy got=%b exp=0000", rd_busy); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'd0) $display("FAIL mid_rst_dbg got=%h exp=0", dbg_data); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL mid_rst_init got=%b exp=0", init_done); else pass_cnt++;
    tick;
    rst = 0;
    for (int i = 1; i <= 31; i++) begin
      tick;
      if (init_done === 1'b0) lows++;
    end
    total_cnt++; if (lows != 31) $display("FAIL mid_sweep_low_cycles got=%0d exp=31", lows); else pass_cnt++;
    tick;
    total_cnt++; if (init_done !== 1'b1) $display("FAIL mid_init_done got=%b exp=1", init_done); else pass_cnt++;
    tick;
    total_cnt++; if (rd_data[31:0] !== 32'd0) $display("FAIL mid_r4_cleared got=%h exp=0", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (rd_busy[1] !== 1'b0) $display("FAIL mid_busy_cleared got=%b exp=0", rd_busy[1]); else pass_cnt++;
  endtask

  initial begin
    rst = 1; pc = 0; rd_addr = '0;
    wa_we = 0; wa_addr = 0; wa_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    sb_set = 0; sb_addr = 0; dbg_addr = 0;
    test_reset;
    test_sweep;
    test_constants;
    test_forwarding;
    test_scoreboard;
    test_nrd4;
    test_midrun_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
